// File: rtl/dm_arbiter.sv
// dm_arbiter: shares the single data-memory port between two requesters.
//   port 0 = pipeline MEM stage, port 1 = DMA / debug loader.
// Each requester uses a valid/ready handshake and gets a one-cycle rvalid
// pulse two cycles after acceptance. Alignment, range and op legality are
// checked at acceptance so DM never sees an illegal write.
// Build option: define DM_ARB_RR_EN for round-robin arbitration; when it is
// undefined, port 0 has fixed priority.
// DMOp codes come from the shared macro header; the fallbacks below are used
// only when that header has not been read first.

`ifndef DM_w
`define DM_w  3'b000
`endif
`ifndef DM_h
`define DM_h  3'b001
`endif
`ifndef DM_hu
`define DM_hu 3'b010
`endif
`ifndef DM_b
`define DM_b  3'b011
`endif
`ifndef DM_bu
`define DM_bu 3'b100
`endif

module dm_arbiter #(
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        r0_valid,
  output logic        r0_ready,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r0_wdata,
  input  logic [2:0]  r0_op,
  input  logic        r0_we,
  input  logic [31:0] r0_pc,
  output logic        r0_rvalid,
  output logic [31:0] r0_rdata,
  output logic        r0_err,

  input  logic        r1_valid,
  output logic        r1_ready,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r1_wdata,
  input  logic [2:0]  r1_op,
  input  logic        r1_we,
  input  logic [31:0] r1_pc,
  output logic        r1_rvalid,
  output logic [31:0] r1_rdata,
  output logic        r1_err,

  output logic [31:0] dm_pc,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wd,
  output logic [2:0]  dm_op,
  output logic        dm_wr,
  input  logic [31:0] dm_rd
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state, state_next;

  // Request captured at acceptance; requesters may change their fields
  // right after the handshake, so everything downstream uses these copies.
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic [2:0]  req_op;
  logic        req_we;
  logic        req_err;
  logic        req_port;
  logic [31:0] resp_data;

  // Arbitration and the selected requester's fields.
  logic        grant;
  logic        accept;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [31:0] sel_pc;
  logic [2:0]  sel_op;
  logic        sel_we;
  logic        sel_err;

  logic        in_access;
  logic        in_resp;

  // A request is illegal when misaligned for its size, beyond the end of
  // DM, an unknown op, or a store with an unsigned-load op.
  function automatic logic req_error(input logic [31:0] addr,
                                     input logic [2:0]  op,
                                     input logic        we);
    logic bad;
    bad = 1'b0;
    case (op)
      `DM_w:   bad = (addr[1:0] != 2'b00);
      `DM_h:   bad = addr[0];
      `DM_hu:  bad = addr[0] | we;
      `DM_b:   bad = 1'b0;
      `DM_bu:  bad = we;
      default: bad = 1'b1;
    endcase
    if (addr >= ADDR_LIMIT) bad = 1'b1;
    return bad;
  endfunction

`ifdef DM_ARB_RR_EN
  // Port preferred on a tie; flips to the other port on every accept, so it
  // always points away from the last grant. Starts at port 0 after reset.
  logic rr_ptr;

  // Tie goes to the pointer; a lone valid port always wins.
  always_comb begin
    grant = (r0_valid & r1_valid) ? rr_ptr : r1_valid;
  end

  // Pointer update on each accepted request.
  always_ff @(posedge clk) begin
    if (reset)       rr_ptr <= 1'b0;
    else if (accept) rr_ptr <= ~grant;
  end
`else
  // Fixed priority: port 1 is granted only when port 0 is not asking.
  always_comb begin
    grant = ~r0_valid;
  end
`endif

  // Handshake: accept only in IDLE, never while reset is asserted.
  always_comb begin
    accept   = (state == IDLE) & ~reset & (r0_valid | r1_valid);
    r0_ready = accept & ~grant;
    r1_ready = accept &  grant;
  end

  // Mux the granted requester's fields and pre-compute its error flag.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path can
    // leave one unassigned and infer a latch.
    sel_addr  = r0_addr;
    sel_wdata = r0_wdata;
    sel_pc    = r0_pc;
    sel_op    = r0_op;
    sel_we    = r0_we;
    if (grant) begin
      sel_addr  = r1_addr;
      sel_wdata = r1_wdata;
      sel_pc    = r1_pc;
      sel_op    = r1_op;
      sel_we    = r1_we;
    end
    sel_err = req_error(sel_addr, sel_op, sel_we);
  end

  // Next-state logic: one request in flight, IDLE -> ACCESS -> RESP -> IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register; reset drops any request in flight.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Request capture at accept and response capture during the DM access.
  always_ff @(posedge clk) begin
    // NOTE: these are ordinary flops (not a memory array), so clearing them
    // in reset is cheap and keeps outputs free of X after reset.
    if (reset) begin
      req_addr  <= 32'h0;
      req_wdata <= 32'h0;
      req_pc    <= 32'h0;
      req_op    <= `DM_w;
      req_we    <= 1'b0;
      req_err   <= 1'b0;
      req_port  <= 1'b0;
      resp_data <= 32'h0;
    end else begin
      if (accept) begin
        req_addr  <= sel_addr;
        req_wdata <= sel_wdata;
        req_pc    <= sel_pc;
        req_op    <= sel_op;
        req_we    <= sel_we;
        req_err   <= sel_err;
        req_port  <= grant;
      end
      if (state == ACCESS) begin
        resp_data <= (~req_we & ~req_err) ? dm_rd : 32'h0;
      end
    end
  end

  // DM port: driven from the captured request only during ACCESS; quiet
  // (and never writing) otherwise, including in a reset cycle.
  always_comb begin
    in_access = (state == ACCESS) & ~reset;
    dm_addr   = 32'h0;
    dm_wd     = 32'h0;
    dm_pc     = 32'h0;
    dm_op     = `DM_w;
    dm_wr     = 1'b0;
    if (in_access) begin
      dm_addr = req_addr;
      dm_wd   = req_wdata;
      dm_pc   = req_pc;
      dm_op   = req_op;
      dm_wr   = req_we & ~req_err;
    end
  end

  // Response pulse steered to the port that owns the request.
  always_comb begin
    in_resp   = (state == RESP) & ~reset;
    r0_rvalid = in_resp & ~req_port;
    r1_rvalid = in_resp &  req_port;
    r0_rdata  = r0_rvalid ? resp_data : 32'h0;
    r1_rdata  = r1_rvalid ? resp_data : 32'h0;
    r0_err    = r0_rvalid & req_err;
    r1_err    = r1_rvalid & req_err;
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed self-checking bench for dm_arbiter with a small
// byte-addressed little-endian DM model behind the arbiter.
`timescale 1ns/1ps

module tb_dm_arbiter;

  localparam logic [2:0] OP_W  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_HU = 3'b010;
  localparam logic [2:0] OP_B  = 3'b011;
  localparam logic [2:0] OP_BU = 3'b100;

  logic        clk = 1'b0;
  logic        reset;
  logic        r0_valid, r0_ready, r0_we, r0_rvalid, r0_err;
  logic [31:0] r0_addr, r0_wdata, r0_pc, r0_rdata;
  logic [2:0]  r0_op;
  logic        r1_valid, r1_ready, r1_we, r1_rvalid, r1_err;
  logic [31:0] r1_addr, r1_wdata, r1_pc, r1_rdata;
  logic [2:0]  r1_op;
  logic [31:0] dm_pc, dm_addr, dm_wd, dm_rd;
  logic [2:0]  dm_op;
  logic        dm_wr;

  int n_vec = 0;
  int n_err = 0;

  dm_arbiter dut (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_op(r0_op), .r0_we(r0_we), .r0_pc(r0_pc), .r0_rvalid(r0_rvalid),
    .r0_rdata(r0_rdata), .r0_err(r0_err),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_op(r1_op), .r1_we(r1_we), .r1_pc(r1_pc), .r1_rvalid(r1_rvalid),
    .r1_rdata(r1_rdata), .r1_err(r1_err),
    .dm_pc(dm_pc), .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_op(dm_op),
    .dm_wr(dm_wr), .dm_rd(dm_rd)
  );

  always #5 clk = ~clk;

  // ---------------- DM model ----------------
  logic [7:0]  mem [0:4095];
  logic [11:0] wa, ha, ba;
  int          wr_count = 0;
  logic [31:0] last_wr_pc = 32'h0;
  logic [31:0] last_wr_addr = 32'h0;

  assign wa = {dm_addr[11:2], 2'b00};
  assign ha = {dm_addr[11:1], 1'b0};
  assign ba = dm_addr[11:0];

  always @(posedge clk) begin
    if (dm_wr) begin
      wr_count     <= wr_count + 1;
      last_wr_pc   <= dm_pc;
      last_wr_addr <= dm_addr;
      case (dm_op)
        OP_W: begin
          mem[wa]         <= dm_wd[7:0];
          mem[wa + 12'd1] <= dm_wd[15:8];
          mem[wa + 12'd2] <= dm_wd[23:16];
          mem[wa + 12'd3] <= dm_wd[31:24];
        end
        OP_H: begin
          mem[ha]         <= dm_wd[7:0];
          mem[ha + 12'd1] <= dm_wd[15:8];
        end
        OP_B:    mem[ba] <= dm_wd[7:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    dm_rd = 32'h0;
    case (dm_op)
      OP_W:  dm_rd = {mem[wa + 12'd3], mem[wa + 12'd2], mem[wa + 12'd1], mem[wa]};
      OP_H:  dm_rd = {{16{mem[ha + 12'd1][7]}}, mem[ha + 12'd1], mem[ha]};
      OP_HU: dm_rd = {16'h0, mem[ha + 12'd1], mem[ha]};
      OP_B:  dm_rd = {{24{mem[ba][7]}}, mem[ba]};
      OP_BU: dm_rd = {24'h0, mem[ba]};
      default: dm_rd = 32'h0;
    endcase
  end

  // All arbiter outputs packed; every bit is zero in the reset/idle state.
  function automatic logic [169:0] out_vec();
    return {r0_ready, r1_ready, r0_rvalid, r1_rvalid, r0_err, r1_err, dm_wr,
            r0_rdata, r1_rdata, dm_pc, dm_addr, dm_wd, dm_op};
  endfunction

  task automatic drive_port(input bit port, input logic v, input logic we,
                            input logic [2:0] op, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] pc);
    if (port == 1'b0) begin
      r0_valid = v; r0_we = we; r0_op = op; r0_addr = addr; r0_wdata = wdata; r0_pc = pc;
    end else begin
      r1_valid = v; r1_we = we; r1_op = op; r1_addr = addr; r1_wdata = wdata; r1_pc = pc;
    end
  endtask

  // One full transaction; fields are scrambled right after the handshake.
  // lat counts cycles from the accept cycle to the rvalid cycle.
  task automatic do_req(input bit port, input logic we, input logic [2:0] op,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] pc, output logic [31:0] rdata,
                        output logic err, output int lat, output bit ok);
    bit got;
    ok = 1'b0; rdata = 32'h0; err = 1'b0; lat = 0;
    @(negedge clk);
    drive_port(port, 1'b1, we, op, addr, wdata, pc);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if ((port ? r1_ready : r0_ready) === 1'b1) got = 1'b1;
      else @(negedge clk);
    end
    if (!got) begin
      drive_port(port, 1'b0, 1'b0, OP_W, 32'h0, 32'h0, 32'h0);
      return;
    end
    @(negedge clk);
    drive_port(port, 1'b0, 1'b1, 3'b111, 32'hFFFF_FFFC, 32'h5A5A_5A5A, 32'hFFFF_FFFF);
    lat = 1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      #1;
      if ((port ? r1_rvalid : r0_rvalid) === 1'b1) begin
        got   = 1'b1;
        rdata = port ? r1_rdata : r0_rdata;
        err   = port ? r1_err : r0_err;
      end else begin
        @(negedge clk);
        lat++;
      end
    end
    ok = got;
  endtask

  // Runs one request and checks completion, latency, data, err and DM writes.
  task automatic run_check(input string name, input bit port, input logic we,
                           input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] pc,
                           input logic [31:0] exp_data, input logic exp_err,
                           input int exp_wr);
    logic [31:0] rd;
    logic        e;
    int          lat, w0;
    bit          ok;
    w0 = wr_count;
    do_req(port, we, op, addr, wdata, pc, rd, e, lat, ok);
    @(negedge clk);
    n_vec++;
    if (ok !== 1'b1 || lat != 2) begin
      n_err++;
      $display("FAIL %s handshake: done=%0d latency=%0d, required done=1 latency=2", name, ok, lat);
    end
    n_vec++;
    if (rd !== exp_data || e !== exp_err) begin
      n_err++;
      $display("FAIL %s response: rdata=%h err=%b, required rdata=%h err=%b", name, rd, e, exp_data, exp_err);
    end
    n_vec++;
    if (wr_count - w0 != exp_wr) begin
      n_err++;
      $display("FAIL %s dm_wr pulses: got %0d, required %0d", name, wr_count - w0, exp_wr);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_port(1'b0, 1'b1, 1'b1, OP_W, 32'h10, 32'h1111_1111, 32'h100);
    drive_port(1'b1, 1'b1, 1'b1, OP_W, 32'h14, 32'h2222_2222, 32'h200);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      n_vec++;
      if (out_vec() !== 170'h0) begin
        n_err++;
        $display("FAIL reset outputs cycle %0d: got %h, required all zero", c, out_vec());
      end
    end
    @(negedge clk);
    drive_port(1'b0, 1'b0, 1'b0, OP_W, 32'h0, 32'h0, 32'h0);
    drive_port(1'b1, 1'b0, 1'b0, OP_W, 32'h0, 32'h0, 32'h0);
    reset = 1'b0;
  endtask

  task automatic test_idle();
    int w0;
    w0 = wr_count;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      n_vec++;
      if (out_vec() !== 170'h0) begin
        n_err++;
        $display("FAIL idle outputs cycle %0d: got %h, required all zero", c, out_vec());
      end
    end
    n_vec++;
    if (wr_count != w0) begin
      n_err++;
      $display("FAIL idle dm_wr: got %0d pulses, required 0", wr_count - w0);
    end
  endtask

  task automatic test_p0_word();
    run_check("p0 store w 0x10", 1'b0, 1'b1, OP_W, 32'h10, 32'hDEAD_BEEF, 32'h0000_0400,
              32'h0, 1'b0, 1);
    n_vec++;
    if (last_wr_pc !== 32'h0000_0400 || last_wr_addr !== 32'h10) begin
      n_err++;
      $display("FAIL p0 write log: pc=%h addr=%h, required pc=00000400 addr=00000010",
               last_wr_pc, last_wr_addr);
    end
    run_check("p0 load w 0x10", 1'b0, 1'b0, OP_W, 32'h10, 32'h0, 32'h0000_0404,
              32'hDEAD_BEEF, 1'b0, 0);
  endtask

  task automatic test_errors();
    run_check("store w misaligned 0x12", 1'b0, 1'b1, OP_W, 32'h12, 32'hCAFE_F00D, 32'h408,
              32'h0, 1'b1, 0);
    run_check("load h 0x1001", 1'b0, 1'b0, OP_H, 32'h1001, 32'h0, 32'h40C, 32'h0, 1'b1, 0);
    run_check("load w at limit 0x1000", 1'b0, 1'b0, OP_W, 32'h1000, 32'h0, 32'h410,
              32'h0, 1'b1, 0);
    run_check("store bu illegal", 1'b1, 1'b1, OP_BU, 32'h10, 32'h0000_0011, 32'h414,
              32'h0, 1'b1, 0);
    run_check("illegal op 6", 1'b0, 1'b0, 3'b110, 32'h10, 32'h0, 32'h418, 32'h0, 1'b1, 0);
    run_check("store w last word 0xFFC", 1'b0, 1'b1, OP_W, 32'hFFC, 32'h0BAD_F00D, 32'h41C,
              32'h0, 1'b0, 1);
    run_check("reload w 0x10", 1'b0, 1'b0, OP_W, 32'h10, 32'h0, 32'h420,
              32'hDEAD_BEEF, 1'b0, 0);
  endtask

  task automatic test_p1_bytes();
    run_check("p1 store b 0x13", 1'b1, 1'b1, OP_B, 32'h13, 32'h0000_0080, 32'h0000_8000,
              32'h0, 1'b0, 1);
    n_vec++;
    if (last_wr_pc !== 32'h0000_8000 || last_wr_addr !== 32'h13) begin
      n_err++;
      $display("FAIL p1 write log: pc=%h addr=%h, required pc=00008000 addr=00000013",
               last_wr_pc, last_wr_addr);
    end
    run_check("p1 load b 0x13", 1'b1, 1'b0, OP_B, 32'h13, 32'h0, 32'h8004,
              32'hFFFF_FF80, 1'b0, 0);
    run_check("p1 load bu 0x13", 1'b1, 1'b0, OP_BU, 32'h13, 32'h0, 32'h8008,
              32'h0000_0080, 1'b0, 0);
  endtask

  // Both ports keep valid high until each has had 6 loads accepted.
  task automatic test_contention();
    bit order [0:11];
    bit expected [0:11];
    int c0, c1, g, n0, n1, bad0, bad1, cyc;
    bit both;
    c0 = 0; c1 = 0; g = 0; n0 = 0; n1 = 0; bad0 = 0; bad1 = 0; cyc = 0; both = 1'b0;
    for (int i = 0; i < 12; i++) begin
      order[i] = 1'b0;
`ifdef DM_ARB_RR_EN
      expected[i] = (i % 2 == 1);
`else
      expected[i] = (i >= 6);
`endif
    end
    while ((g < 12 || n0 + n1 < 12) && cyc < 300) begin
      @(negedge clk);
      drive_port(1'b0, c0 < 6, 1'b0, OP_W, 32'h10, 32'h0, 32'h500);
      drive_port(1'b1, c1 < 6, 1'b0, OP_BU, 32'h13, 32'h0, 32'h9000);
      #1;
      if (r0_ready === 1'b1 && r1_ready === 1'b1) both = 1'b1;
      if (r0_ready === 1'b1 && g < 12) begin order[g] = 1'b0; g++; c0++; end
      else if (r1_ready === 1'b1 && g < 12) begin order[g] = 1'b1; g++; c1++; end
      if (r0_rvalid === 1'b1) begin n0++; if (r0_rdata !== 32'h80AD_BEEF) bad0++; end
      if (r1_rvalid === 1'b1) begin n1++; if (r1_rdata !== 32'h0000_0080) bad1++; end
      cyc++;
    end
    @(negedge clk);
    drive_port(1'b0, 1'b0, 1'b0, OP_W, 32'h0, 32'h0, 32'h0);
    drive_port(1'b1, 1'b0, 1'b0, OP_W, 32'h0, 32'h0, 32'h0);
    n_vec++;
    if (both !== 1'b0) begin
      n_err++;
      $display("FAIL contention: both readies high in one cycle, required never");
    end
    n_vec++;
    if (g != 12 || n0 != 6 || n1 != 6) begin
      n_err++;
      $display("FAIL contention counts: grants=%0d resp0=%0d resp1=%0d, required 12/6/6", g, n0, n1);
    end
    n_vec++;
    if (bad0 != 0 || bad1 != 0) begin
      n_err++;
      $display("FAIL contention data: bad port0=%0d bad port1=%0d, required 0/0", bad0, bad1);
    end
    for (int i = 0; i < 12; i++) begin
      n_vec++;
      if (order[i] !== expected[i]) begin
        n_err++;
        $display("FAIL contention grant %0d: port %0d, required port %0d", i, order[i], expected[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int w0, rv;
    bit got;
    run_check("pre store w 0x20", 1'b0, 1'b1, OP_W, 32'h20, 32'hA5A5_A5A5, 32'h600,
              32'h0, 1'b0, 1);
    w0 = wr_count;
    @(negedge clk);
    drive_port(1'b0, 1'b1, 1'b1, OP_W, 32'h20, 32'h1234_5678, 32'h604);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      #1;
      if (r0_ready === 1'b1) got = 1'b1;
      else @(negedge clk);
    end
    n_vec++;
    if (got !== 1'b1) begin
      n_err++;
      $display("FAIL reset-mid accept: ready never seen, required within 10 cycles");
    end
    @(negedge clk);
    drive_port(1'b0, 1'b0, 1'b0, OP_W, 32'h0, 32'h0, 32'h0);
    reset = 1'b1;
    #1;
    n_vec++;
    if (dm_wr !== 1'b0) begin
      n_err++;
      $display("FAIL reset-mid dm_wr in reset cycle: got %b, required 0", dm_wr);
    end
    @(negedge clk);
    reset = 1'b0;
    rv = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (r0_rvalid === 1'b1 || r1_rvalid === 1'b1) rv++;
      @(negedge clk);
    end
    n_vec++;
    if (rv != 0 || wr_count != w0) begin
      n_err++;
      $display("FAIL reset-mid aftermath: rvalids=%0d writes=%0d, required 0/0", rv, wr_count - w0);
    end
    run_check("post-reset load w 0x20", 1'b0, 1'b0, OP_W, 32'h20, 32'h0, 32'h608,
              32'hA5A5_A5A5, 1'b0, 0);
  endtask

  initial begin
    reset = 1'b1;
    drive_port(1'b0, 1'b0, 1'b0, OP_W, 32'h0, 32'h0, 32'h0);
    drive_port(1'b1, 1'b0, 1'b0, OP_W, 32'h0, 32'h0, 32'h0);
    test_reset();
    test_idle();
    test_p0_word();
    test_errors();
    test_p1_bytes();
    test_contention();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within 200000 ns");
    $fatal(1);
  end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
Shares the single data-memory (DM) port between two requesters: port 0 (pipeline MEM stage) and port 1 (DMA/debug loader). Uses a valid/ready request handshake and returns a one-cycle response pulse. Checks alignment and range before a request reaches DM, so DM never sees an illegal write. Sits between the requesters and the DM instance; DM keeps its own clk/reset.

Parameters:
ADDR_LIMIT, 32'h0000_1000, first illegal byte address (DM is 1024 words = 4 KB); addr >= ADDR_LIMIT is an error.

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
rN_valid  in  1  request valid, N = 0,1
rN_ready  out  1  request accepted this cycle (combinational)
rN_addr  in  32  byte address
rN_wdata  in  32  store data (low bits used for h/b)
rN_op  in  3  DMOp code: DM_w, DM_h, DM_hu, DM_b, DM_bu from shared macro header
rN_we  in  1  1 = store, 0 = load
rN_pc  in  32  PC for the DM write log
rN_rvalid  out  1  one-cycle response pulse
rN_rdata  out  32  load data; 0 for stores and errors
rN_err  out  1  valid with rN_rvalid: misaligned, out of range or illegal op
dm_pc  out  32  to DM pc
dm_addr  out  32  to DM Addr
dm_wd  out  32  to DM WD
dm_op  out  3  to DM DMOp
dm_wr  out  1  to DM DMWr
dm_rd  in  32  from DM RD (combinational read)

Behaviour:
- FSM states: IDLE, ACCESS, RESP. One outstanding request total. Latency: accept at cycle T, DM access at T+1, rvalid at T+2. Peak throughput 1 request per 3 cycles.
- IDLE:
  - rN_ready = 1 only for the granted requester, only when its rN_valid = 1.
  - Grant selection: without the optional feature, port 0 always has priority.
  - On accept, latch addr, wdata, op, we, pc, grant id and err; go to ACCESS.
  - Only one rN_ready is high in any cycle. No requester valid -> stay in IDLE.
- err computation at accept:
  - DM_w needs addr[1:0] = 0.
  - DM_h and DM_hu need addr[0] = 0.
  - DM_b and DM_bu accept any alignment.
  - addr >= ADDR_LIMIT -> err.
  - Any other op code -> err.
  - Stores with DM_hu or DM_bu -> err.
- ACCESS:
  - dm_addr, dm_op, dm_wd and dm_pc come from the latched values.
  - dm_wr = latched we & ~err, high for exactly this cycle.
  - For a load without err, capture dm_rd into the response register.
  - Go to RESP.
- RESP:
  - rN_rvalid = 1 for the latched grant only.
  - rN_rdata = captured data, or 0 for a store or an error. rN_err = latched err.
  - Go to IDLE. A new request can be accepted in the following IDLE cycle, not during RESP.
- Outside ACCESS: dm_wr = 0, dm_op = DM_w, dm_addr = 0, dm_wd = 0, dm_pc = 0.
- The requester holds its request fields only until its ready handshake. The arbiter must not rely on them afterwards.
- Reset values: state IDLE; all rN_ready, rN_rvalid, rN_err = 0; rN_rdata = 0; dm_wr = 0; dm_* = 0 (dm_op = DM_w); round-robin pointer = port 0.
- Reset mid-operation: a pending request is dropped with no rvalid, and no dm_wr is issued in the reset cycle.
- A requester that keeps valid high after rvalid is treated as a new request.

Optional Feature:
DM_ARB_RR_EN
- Defined: round-robin arbitration.
  - A 1-bit last-grant register updates on each accept.
  - When both ports are valid in IDLE, grant the port not granted last.
  - With only one port valid, that port is granted regardless of the pointer.
- Undefined: fixed priority, port 0 wins. Port 1 can starve; this is acceptable in that build.

Test Plan:
- Port 0 store DM_w addr 0x10 wdata 0xDEADBEEF, then port 0 load DM_w 0x10:
  - dm_wr pulses once.
  - Load response r0_rdata = 0xDEADBEEF, err = 0, rvalid 2 cycles after ready.
- Port 1 store DM_b addr 0x13 wdata 0x80, then load DM_b 0x13 and load DM_bu 0x13 -> rdata 0xFFFFFF80, then 0x00000080.
- Port 0 store DM_w addr 0x12, and load DM_h addr 0x1001:
  - Each gives err = 1, rdata = 0, no dm_wr.
  - A following load DM_w 0x10 still returns the original data.
- Both ports valid for 6 requests each:
  - Fixed priority: all port 0 grants first.
  - DM_ARB_RR_EN: grants alternate 0,1,0,1…
  - In both builds, never two readies in one cycle.
- Reset asserted during ACCESS of a store: no rvalid; the FSM is in IDLE after reset.
- Idle bus, no valids for 10 cycles: all outputs hold reset values, dm_wr = 0 throughout.
